alu_ctrl: RTL and testbench

- Initiator/sequencer for the 8-bit combinational ALU (`alu`: in0/in1/sel/en in, 16-bit tristate out).
- Accepts operation commands over a valid/ready interface and drives the ALU operands, select and enable.
- Samples the ALU result only while `alu_en` is high, then returns the registered 16-bit result over a valid/ready response interface.
- Sits between a command source (test sequencer / simple CPU datapath) and the `alu` instance.

---
 rtl/alu_ctrl_pkg.sv | 31 +++
 rtl/alu_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencer.
// Op encodings match the combinational alu select field.
package alu_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  localparam logic [SEL_W-1:0] ADD_SEL = 3'b000;
  localparam logic [SEL_W-1:0] SUB_SEL = 3'b001;
  localparam logic [SEL_W-1:0] SHR_SEL = 3'b010;
  localparam logic [SEL_W-1:0] SHL_SEL = 3'b011;
  localparam logic [SEL_W-1:0] AND_SEL = 3'b100;
  localparam logic [SEL_W-1:0] OR_SEL  = 3'b101;
  localparam logic [SEL_W-1:0] XOR_SEL = 3'b110;
  localparam logic [SEL_W-1:0] NOT_SEL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } ctrl_state_e;

  function automatic logic res_zero(
    input logic [RES_W-1:0] r
  );
    return r == '0;
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Command/response sequencer driving the 8-bit ALU.
// Optional ALU_CTRL_CHAIN_EN adds cmd_chain to feed back the last result.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_CTRL_CHAIN_EN
  input  logic              cmd_chain,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic [SEL_W-1:0]  rsp_op,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              alu_en,
  input  logic [RES_W-1:0]  alu_out,
  output logic              busy
);

  localparam logic [CNT_W-1:0] SETTLE_LD =
    CNT_W'(SETTLE_CYC - 1);

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] in0_q, in0_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              en_q, en_d;
  logic              rv_q, rv_d;
  logic [RES_W-1:0]  rd_q, rd_d;
  logic [SEL_W-1:0]  rop_q, rop_d;
  logic              rz_q, rz_d;
  logic [DATA_W-1:0] in0_src;

`ifdef ALU_CTRL_CHAIN_EN
  assign in0_src = cmd_chain ? rd_q[DATA_W-1:0] : cmd_a;
`else
  assign in0_src = cmd_a;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    sel_d   = sel_q;
    en_d    = en_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    rop_d   = rop_q;
    rz_d    = rz_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          in0_d   = in0_src;
          in1_d   = cmd_b;
          sel_d   = cmd_op;
          cnt_d   = SETTLE_LD;
          en_d    = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // alu_out is only ever looked at here, with en held high
        if (cnt_q == '0) begin
          rd_d    = alu_out;
          rop_d   = sel_q;
          rz_d    = res_zero(alu_out);
          en_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rop_q   <= '0;
      rz_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rop_q   <= rop_d;
      rz_q    <= rz_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rv_q;
  assign rsp_data  = rd_q;
  assign rsp_op    = rop_q;
  assign rsp_zero  = rz_q;
  assign alu_in0   = in0_q;
  assign alu_in1   = in1_q;
  assign alu_sel   = sel_q;
  assign alu_en    = en_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl with a behavioural 8-bit ALU as responder.
// Build with ALU_CTRL_CHAIN_EN to cover the chained-operand path.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  parameter int SETTLE = 1;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
`ifdef ALU_CTRL_CHAIN_EN
  logic        cmd_chain;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_op;
  logic        rsp_zero;
  logic [7:0]  alu_in0;
  logic [7:0]  alu_in1;
  logic [2:0]  alu_sel;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        busy;

  logic        z_mode;
  logic [15:0] alu_res;
  logic [15:0] a16;
  logic [15:0] b16;

  alu_ctrl #(.SETTLE_CYC(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
`ifdef ALU_CTRL_CHAIN_EN
    .cmd_chain (cmd_chain),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op),
    .rsp_zero  (rsp_zero),
    .alu_in0   (alu_in0),
    .alu_in1   (alu_in1),
    .alu_sel   (alu_sel),
    .alu_en    (alu_en),
    .alu_out   (alu_out),
    .busy      (busy)
  );

  // behavioural ALU: zero-extended 8-bit operands, 16-bit result
  assign a16 = {8'h00, alu_in0};
  assign b16 = {8'h00, alu_in1};

  always_comb begin
    alu_res = '0;
    unique case (alu_sel)
      ADD_SEL: alu_res = a16 + b16;
      SUB_SEL: alu_res = a16 - b16;
      SHR_SEL: alu_res = a16 >> 1;
      SHL_SEL: alu_res = a16 << 1;
      AND_SEL: alu_res = a16 & b16;
      OR_SEL:  alu_res = a16 | b16;
      XOR_SEL: alu_res = a16 ^ b16;
      NOT_SEL: alu_res = ~a16;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    if (!alu_en)
      alu_out = 16'hzzzz;
    else if (z_mode)
      alu_out = 16'h1234;
    else
      alu_out = alu_res;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] d;
    logic        z;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   passed;
  int   total;
  int   en_run;
  int   en_last;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // scoreboard: pop on every response handshake
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
        chk("rsp_op", {29'h0, rsp_op}, {29'h0, e.op});
        chk("rsp_zero", {31'h0, rsp_zero}, {31'h0, e.zero});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      en_run <= 0;
    end else if (alu_en) begin
      en_run <= en_run + 1;
    end else begin
      if (en_run > 0) en_last <= en_run;
      en_run <= 0;
    end
  end

  // callers are always at posedge+1
  task automatic issue(
    input logic [2:0]  op,
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic        ch,
    input logic        push,
    input logic [15:0] d,
    input logic        z
  );
    exp_t e;
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("issue_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
`ifdef ALU_CTRL_CHAIN_EN
    cmd_chain = ch;
`else
    if (ch) $display("chain request ignored");
`endif
    if (push) begin
      e.op = op; e.data = d; e.zero = z;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
`ifdef ALU_CTRL_CHAIN_EN
    cmd_chain = 1'b0;
`endif
  endtask

  task automatic wait_rsp();
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, SETTLE);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    int seen;
    passed  = 0;
    total   = 0;
    z_mode  = 1'b0;
    rst_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op  = '0;
    cmd_a   = '0;
    cmd_b   = '0;
`ifdef ALU_CTRL_CHAIN_EN
    cmd_chain = 1'b0;
`endif
    rsp_ready = 1'b1;

    vecs[0] = '{ADD_SEL, 8'hFF, 8'h01, 16'h0100, 1'b0};
    vecs[1] = '{SUB_SEL, 8'h03, 8'h05, 16'hFFFE, 1'b0};
    vecs[2] = '{NOT_SEL, 8'h0F, 8'h00, 16'hFFF0, 1'b0};
    vecs[3] = '{SHL_SEL, 8'h81, 8'h00, 16'h0102, 1'b0};
    vecs[4] = '{XOR_SEL, 8'h5A, 8'h5A, 16'h0000, 1'b1};
    vecs[5] = '{AND_SEL, 8'hF0, 8'h3C, 16'h0030, 1'b0};
    vecs[6] = '{OR_SEL,  8'h0F, 8'hA0, 16'h00AF, 1'b0};
    vecs[7] = '{SHR_SEL, 8'h81, 8'h00, 16'h0040, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'h0, rsp_data}, 32'd0);
    chk("rst_rsp_op", {29'h0, rsp_op}, 32'd0);
    chk("rst_rsp_zero", {31'h0, rsp_zero}, 32'd1);
    chk("rst_alu_ops", {8'h0, alu_in0, alu_in1, 5'h0, alu_sel},
        32'd0);
    chk("rst_alu_en", {31'h0, alu_en}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b1,
            vecs[i].d, vecs[i].z);
      wait_rsp();
      wait_idle();
      chk("en_cycles", en_last, SETTLE);
      chk("hold_ops", {8'h0, alu_in0, alu_in1, 5'h0, alu_sel},
          {8'h0, vecs[i].a, vecs[i].b, 5'h0, vecs[i].op});
      chk("idle_en", {31'h0, alu_en}, 32'd0);
    end

    // backpressure with a competing command held valid
    rsp_ready = 1'b0;
    issue(ADD_SEL, 8'h12, 8'h34, 1'b0, 1'b1, 16'h0046, 1'b0);
    wait_rsp();
    cmd_valid = 1'b1;
    cmd_op    = ADD_SEL;
    cmd_a     = 8'h01;
    cmd_b     = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'h0, rsp_valid}, 32'd1);
      chk("bp_data", {16'h0, rsp_data}, 32'h0046);
      chk("bp_op", {29'h0, rsp_op}, {29'h0, ADD_SEL});
      chk("bp_ready", {31'h0, cmd_ready}, 32'd0);
      chk("bp_en", {31'h0, alu_en}, 32'd0);
      chk("bp_in0", {24'h0, alu_in0}, 32'h12);
    end
    begin
      exp_t e;
      e.op = ADD_SEL; e.data = 16'h0002; e.zero = 1'b0;
      exp_q.push_back(e);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_busy", {31'h0, busy}, 32'd0);
    chk("bp_hs_en", {31'h0, alu_en}, 32'd0);
    chk("bp_hs_in0", {24'h0, alu_in0}, 32'h12);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp2_en", {31'h0, alu_en}, 32'd1);
    chk("bp2_in0", {24'h0, alu_in0}, 32'h01);
    wait_rsp();
    wait_idle();

    // undriven alu_out outside DRIVE must not leak into the result
    z_mode = 1'b1;
    issue(OR_SEL, 8'hAA, 8'h55, 1'b0, 1'b1, 16'h1234, 1'b0);
    wait_rsp();
    chk("z_known", {31'h0, $isunknown(rsp_data)}, 32'd0);
    wait_idle();
    z_mode = 1'b0;

    // reset in the middle of DRIVE
    issue(SUB_SEL, 8'h07, 8'h02, 1'b0, 1'b0, 16'h0005, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", {31'h0, busy}, 32'd0);
    chk("mr_ready", {31'h0, cmd_ready}, 32'd1);
    chk("mr_valid", {31'h0, rsp_valid}, 32'd0);
    chk("mr_data", {16'h0, rsp_data}, 32'd0);
    chk("mr_zero", {31'h0, rsp_zero}, 32'd1);
    chk("mr_alu", {7'h0, alu_en, alu_in0, alu_in1, 5'h0, alu_sel},
        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("mr_no_pulse", seen, 0);
    issue(AND_SEL, 8'hF0, 8'h3C, 1'b0, 1'b1, 16'h0030, 1'b0);
    wait_rsp();
    wait_idle();

`ifdef ALU_CTRL_CHAIN_EN
    issue(ADD_SEL, 8'h10, 8'h20, 1'b0, 1'b1, 16'h0030, 1'b0);
    wait_rsp();
    wait_idle();
    issue(ADD_SEL, 8'hFF, 8'h01, 1'b1, 1'b1, 16'h0031, 1'b0);
    chk("chain_in0", {24'h0, alu_in0}, 32'h30);
    wait_rsp();
    wait_idle();
`endif

    repeat (2) @(posedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
